// File: rtl/instr_fetch.sv
// instr_fetch: RISC-V fetch stage with PC, one-deep skid buffer, stall, redirect/flush.
// Optional FETCH_MISALIGN_EN: misaligned redirect target halts fetch and flags instr_misaligned.
module instr_fetch #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  input  logic                  id_ready,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [ADDR_WIDTH-1:0] pc_plus4,
  output logic                  instr_misaligned
);
  typedef enum logic [1:0] {REQ, WAIT, SKID `ifdef FETCH_MISALIGN_EN , HALT `endif} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, req_pc_q, req_pc_d, skid_pc_q, skid_pc_d;
  logic [ADDR_WIDTH-1:0] ifid_pc_q, ifid_pc_d, ifid_pc4_q, ifid_pc4_d, tgt;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d, ifid_data_q, ifid_data_d;
  logic discard_q, discard_d, skid_v_q, skid_v_d, ifid_v_q, ifid_v_d, mis_q, mis_d, halted;
  assign tgt = redirect_target & ~ADDR_WIDTH'(3);
`ifdef FETCH_MISALIGN_EN
  assign halted = state_q == HALT;
`else
  assign halted = 1'b0;
`endif
  assign imem_req_valid = state_q == REQ && !redirect;
  assign imem_addr = pc_q;
  assign instr_valid = ifid_v_q;
  assign instr = ifid_data_q;
  assign pc_out = ifid_pc_q;
  assign pc_plus4 = ifid_pc4_q;
  assign instr_misaligned = mis_q;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    req_pc_d = req_pc_q;
    discard_d = discard_q;
    skid_v_d = skid_v_q;
    skid_data_d = skid_data_q;
    skid_pc_d = skid_pc_q;
    ifid_v_d = ifid_v_q;
    ifid_data_d = ifid_data_q;
    ifid_pc_d = ifid_pc_q;
    ifid_pc4_d = ifid_pc4_q;
    mis_d = mis_q;
    if (redirect && !halted) begin
      pc_d = tgt;
      ifid_v_d = 1'b0;
      ifid_data_d = NOP_INSTR;
      skid_v_d = 1'b0;
      discard_d = state_q == WAIT && !imem_rsp_valid;
      state_d = discard_d ? WAIT : REQ;
`ifdef FETCH_MISALIGN_EN
      if (|redirect_target[1:0]) begin
        pc_d = pc_q;
        discard_d = 1'b0;
        mis_d = 1'b1;
        state_d = HALT;
      end
`endif
    end else begin
      if (id_ready) begin
        ifid_v_d = 1'b0;
        ifid_data_d = NOP_INSTR;
      end
      case (state_q)
        REQ: if (imem_req_valid && imem_req_ready) begin
          req_pc_d = pc_q;
          pc_d = pc_q + ADDR_WIDTH'(4);
          state_d = WAIT;
        end
        WAIT: if (imem_rsp_valid) begin
          state_d = REQ;
          if (discard_q) discard_d = 1'b0;
          else if (!ifid_v_q || id_ready) begin
            ifid_v_d = 1'b1;
            ifid_data_d = imem_rsp_data;
            ifid_pc_d = req_pc_q;
            ifid_pc4_d = req_pc_q + ADDR_WIDTH'(4);
          end else begin
            skid_v_d = 1'b1;
            skid_data_d = imem_rsp_data;
            skid_pc_d = req_pc_q;
            state_d = SKID;
          end
        end
        SKID: if (id_ready) begin
          ifid_v_d = 1'b1;
          ifid_data_d = skid_data_q;
          ifid_pc_d = skid_pc_q;
          ifid_pc4_d = skid_pc_q + ADDR_WIDTH'(4);
          skid_v_d = 1'b0;
          state_d = REQ;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= REQ;
      pc_q <= RESET_PC;
      req_pc_q <= '0;
      discard_q <= 1'b0;
      skid_v_q <= 1'b0;
      skid_data_q <= '0;
      skid_pc_q <= '0;
      ifid_v_q <= 1'b0;
      ifid_data_q <= NOP_INSTR;
      ifid_pc_q <= '0;
      ifid_pc4_q <= ADDR_WIDTH'(4);
      mis_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      req_pc_q <= req_pc_d;
      discard_q <= discard_d;
      skid_v_q <= skid_v_d;
      skid_data_q <= skid_data_d;
      skid_pc_q <= skid_pc_d;
      ifid_v_q <= ifid_v_d;
      ifid_data_q <= ifid_data_d;
      ifid_pc_q <= ifid_pc_d;
      ifid_pc4_q <= ifid_pc4_d;
      mis_q <= mis_d;
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: random/directed stimulus; scoreboard of the expected program-order stream
// (sequential PCs restarting at each redirect target) checked by an independent monitor.
module tb_instr_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 0, rst_n = 0;
  logic imem_req_valid, imem_req_ready, imem_rsp_valid, id_ready, redirect;
  logic instr_valid, instr_misaligned;
  logic [31:0] imem_addr, imem_rsp_data, redirect_target, instr, pc_out, pc_plus4;
  typedef struct packed {logic [31:0] pc; logic [31:0] data;} ent_t;
  ent_t q[$];
  int n_chk = 0, n_pass = 0, n_cons = 0, lat_min = 0, lat_max = 0, pend_cnt = 0;
  bit rdy_rand = 0, idr_rand = 0, idr_val = 1, redir = 0, redir_rand = 0;
  logic pend = 0, l_acc = 0, l_rsp = 0;
  logic [31:0] pend_addr = 0, l_addr = 0, next_pc = 0, redir_tgt = 0;

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .id_ready(id_ready), .redirect(redirect), .redirect_target(redirect_target),
    .instr_valid(instr_valid), .instr(instr), .pc_out(pc_out), .pc_plus4(pc_plus4),
    .instr_misaligned(instr_misaligned)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a == 0 ? 32'h0050_0093 : (a * 32'h9E37_79B1) ^ 32'h13;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic latch();
    l_rsp = imem_rsp_valid;
    l_acc = rst_n && imem_req_valid && imem_req_ready;
    l_addr = imem_addr;
    if (l_acc) begin
      chk("addr_align", {30'b0, l_addr[1:0]}, 0);
      chk("one_outstanding", {31'b0, pend & ~l_rsp}, 0);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (l_rsp) pend = 0;
    if (l_acc) begin
      pend = 1;
      pend_addr = l_addr;
      pend_cnt = $urandom_range(lat_min, lat_max);
    end else if (pend && pend_cnt > 0) pend_cnt--;
    #1;
    imem_rsp_valid = pend && pend_cnt == 0;
    imem_rsp_data = imem_rsp_valid ? memf(pend_addr) : $urandom;
    imem_req_ready = rdy_rand ? 1'($urandom) : 1'b1;
    id_ready = idr_rand ? ($urandom_range(0, 3) != 0) : idr_val;
    redirect = redir || (redir_rand && $urandom_range(0, 15) == 0);
    if (redirect) begin
      redirect_target = redir ? redir_tgt :
                        ($urandom_range(0, 7) == 0 ? 32'hFFFF_FFFC : 32'($urandom_range(0, 1023)) << 2);
      q.delete();
      next_pc = redirect_target & ~32'd3;
    end
    while (q.size() < 4) begin
      q.push_back(ent_t'{next_pc, memf(next_pc)});
      next_pc += 4;
    end
    @(negedge clk);
    latch();
  endtask

  task automatic wait_acc(input int lim);
    for (int k = 0; k < lim && !l_acc; k++) cyc();
    chk("accept_within_budget", {31'b0, l_acc}, 1);
  endtask

  always @(negedge clk) if (rst_n) begin
    if (!instr_valid) chk("nop_when_invalid", instr, NOP);
    else if (id_ready && !redirect) begin
      if (q.size() > 0) begin
        ent_t e;
        e = q.pop_front();
        chk("stream_pc", pc_out, e.pc);
        chk("stream_instr", instr, e.data);
        chk("stream_pc_plus4", pc_plus4, e.pc + 32'd4);
        n_cons++;
      end else chk("stream_underflow", pc_out, 32'hFFFF_FFFF);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0;
    imem_req_ready = 1; imem_rsp_valid = 0; imem_rsp_data = 0;
    id_ready = 1; redirect = 0; redirect_target = 0;
    while (q.size() < 4) begin
      q.push_back(ent_t'{next_pc, memf(next_pc)});
      next_pc += 4;
    end
    repeat (3) @(negedge clk);
    chk("rst_instr_valid", {31'b0, instr_valid}, 0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc_out", pc_out, 0);
    chk("rst_pc_plus4", pc_plus4, 4);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 1);
    chk("rst_addr", imem_addr, 0);
    chk("rst_misaligned", {31'b0, instr_misaligned}, 0);
    rst_n = 1;
    #1 latch();
    chk("first_req_acc", {31'b0, l_acc}, 1);
    chk("first_req_addr", l_addr, 0);
    // zero-wait memory: accept at E1, word captured at E2
    cyc();
    chk("valid_after_accept_edge", {31'b0, instr_valid}, 0);
    idr_val = 0;
    cyc();
    chk("first_valid", {31'b0, instr_valid}, 1);
    chk("first_instr", instr, 32'h0050_0093);
    chk("first_pc_out", pc_out, 0);
    chk("first_pc_plus4", pc_plus4, 4);
    chk("second_req_acc", {31'b0, l_acc}, 1);
    chk("second_req_addr", l_addr, 4);
    // decode stalled: word 4 lands in skid, no request for 8
    cyc();
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("no_req_while_skid", {31'b0, l_acc}, 0);
    end
    chk("stall_hold_pc", pc_out, 0);
    chk("stall_hold_valid", {31'b0, instr_valid}, 1);
    idr_val = 1;
    c0 = n_cons;
    repeat (10) cyc();
    chk("stall_release_count", {31'b0, n_cons >= c0 + 3}, 1);
    // redirect with request in flight
    lat_min = 2; lat_max = 2;
    wait_acc(20);
    redir = 1; redir_tgt = 32'h100;
    cyc();
    redir = 0;
    cyc();
    chk("redir_flush_valid", {31'b0, instr_valid}, 0);
    wait_acc(20);
    chk("redir_target_req", l_addr, 32'h100);
    repeat (6) cyc();
    // redirect coinciding with the response
    lat_min = 0; lat_max = 0;
    wait_acc(20);
    redir = 1; redir_tgt = 32'h200;
    cyc();
    redir = 0;
    cyc();
    chk("redir_rsp_valid", {31'b0, instr_valid}, 0);
    chk("redir_rsp_acc", {31'b0, l_acc}, 1);
    chk("redir_rsp_addr", l_addr, 32'h200);
    repeat (6) cyc();
    // PC wrap
    redir = 1; redir_tgt = 32'hFFFF_FFFC;
    cyc();
    redir = 0;
    wait_acc(20);
    chk("wrap_req_addr", l_addr, 32'hFFFF_FFFC);
    cyc();
    wait_acc(20);
    chk("wrap_next_addr", l_addr, 0);
    chk("wrap_pc_out", pc_out, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", pc_plus4, 0);
    repeat (6) cyc();
    // randomized traffic
    rdy_rand = 1; idr_rand = 1; redir_rand = 1; lat_min = 0; lat_max = 3;
    c0 = n_cons;
    repeat (3000) cyc();
    chk("random_progress", {31'b0, n_cons >= c0 + 100}, 1);
    rdy_rand = 0; idr_rand = 0; redir_rand = 0; lat_max = 0;
    repeat (8) cyc();
    // misaligned redirect
    redir = 1; redir_tgt = 32'h102;
    cyc();
    redir = 0;
    cyc();
`ifdef FETCH_MISALIGN_EN
    chk("misaligned_flag", {31'b0, instr_misaligned}, 1);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("halt_no_req", {31'b0, imem_req_valid}, 0);
      chk("halt_no_valid", {31'b0, instr_valid}, 0);
    end
    redir = 1; redir_tgt = 32'h200;
    cyc();
    redir = 0;
    cyc();
    chk("halt_ignores_redirect", {31'b0, l_acc}, 0);
    chk("misaligned_sticky", {31'b0, instr_misaligned}, 1);
`else
    wait_acc(20);
    chk("misalign_forced_addr", l_addr, 32'h100);
    chk("misaligned_tied_low", {31'b0, instr_misaligned}, 0);
    repeat (6) cyc();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
